pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central pipeline controller for the 5-stage RV32 core.
- Drives the per-stage stall vector and the jump/interrupt flush strobes consumed by the if_id, id_exe, exe_mem and mem_wb pipeline registers.
- Arbitrates stall requests from IF/ID/EXE/MEM.
- Defers a jump or interrupt redirect that arrives while downstream stages are frozen.
- Provides a bus-stall watchdog.

Parameters:
- ADDR_WIDTH, 32, PC/redirect address width.
- WDOG_CYCLES, 1024, consecutive MEM-stall cycles before timeout_o pulses.
- WDOG_W, 11, watchdog counter width; must satisfy 2^WDOG_W > WDOG_CYCLES.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  asynchronous, active-high reset.
- stallreq_if_i  in  1  instruction bus wait.
- stallreq_id_i  in  1  load-use hazard from id.
- stallreq_exe_i  in  1  multi-cycle EXE op busy (div).
- stallreq_mem_i  in  1  data bus wait.
- jump_req_i  in  1  taken branch/jump resolved in EXE.
- jump_addr_i  in  ADDR_WIDTH  jump target.
- int_req_i  in  1  interrupt/exception redirect request from clint.
- int_addr_i  in  ADDR_WIDTH  trap vector.
- stall_o  out  6  per-stage stall, STOP=1. Bit map: [0] pc, [1] if_id, [2] id_exe, [3] exe_mem, [4] mem_wb, [5] wb.
- flush_jump_o  out  1  one-cycle jump flush.
- flush_int_o  out  1  one-cycle interrupt flush.
- redirect_o  out  1  PC load strobe.
- redirect_addr_o  out  ADDR_WIDTH  PC load value.
- int_ack_o  out  1  one-cycle accept pulse to clint.
- timeout_o  out  1  one-cycle watchdog pulse.

Behaviour:
- Reset (async, rst_i=1): FSM=IDLE, pending-jump flag=0, stored addresses=0, watchdog counter=0. Outputs: stall_o=6'b0, all strobes=0, redirect_addr_o=0.
- Stall vector: combinational from requests, same cycle. Fixed priority MEM > EXE > ID > IF:
  - mem: 6'b011111
  - exe: 6'b001111
  - id: 6'b000111 (id_exe sees stall[2]=STOP, stall[3]=NOSTOP and inserts a bubble)
  - if: 6'b000011
  - none: 6'b000000
- Frozen condition F = stallreq_mem_i | stallreq_exe_i.
- Jump path:
  - jump_req_i & !F & FSM==IDLE: assert flush_jump_o and redirect_o, redirect_addr_o=jump_addr_i, same cycle.
  - jump_req_i & F: latch pending=1 and jump_addr_i. The first cycle with !F emits flush_jump_o, redirect_o and the stored address, then clears pending.
  - A new jump_req_i while pending overwrites the stored address.
- Flush overrides stall for flushed stages: while flush_jump_o=1, stall_o bits [2:0] are forced 0.
- Interrupt FSM, states IDLE, DRAIN, FLUSH:
  - IDLE --int_req_i & F--> DRAIN: store int_addr_i.
  - IDLE --int_req_i & !F--> FLUSH: store int_addr_i.
  - DRAIN --!F--> FLUSH.
  - FLUSH --> IDLE (unconditional, one cycle).
  - In FLUSH: flush_int_o=1, redirect_o=1, redirect_addr_o=stored vector, int_ack_o=1, stall_o=0, pending jump cleared.
  - int_req_i is ignored outside IDLE.
- Simultaneous jump and interrupt (same cycle, or jump pending when the FSM leaves IDLE): the interrupt wins. The jump is discarded, flush_jump_o is not asserted, and only one redirect occurs.
- redirect_o is never asserted with both flushes; flush_jump_o and flush_int_o are mutually exclusive.
- Watchdog:
  - Counter increments each cycle stallreq_mem_i=1 and clears when it is 0.
  - On reaching WDOG_CYCLES-1 with stallreq_mem_i still 1: pulse timeout_o for one cycle, then restart the counter from 0 (saturation-free wrap).
  - timeout_o does not alter the stall vector.
- Reset mid-operation (DRAIN or pending jump) abandons the redirect; no strobe fires after reset deasserts.

Decomposition:
- Shared defines: STOP/NOSTOP, the stall-vector encodings (STALL_MEM, STALL_EXE, STALL_ID, STALL_IF, STALL_NONE), stage bit indices, and FSM state encodings. These go in defines.v next to the existing pipeline constants.
- One natural sub-module: pipe_ctrl_wdog (watchdog counter, parameterised by WDOG_CYCLES/WDOG_W).

Test Plan:
- Arbitration: stallreq_id_i=1 alone → stall_o=000111; then add stallreq_mem_i=1 in the same cycle → stall_o=011111; release all → 000000 next evaluation.
- Unfrozen jump: jump_req_i=1, jump_addr_i=0x80000040, no stalls → same cycle flush_jump_o=1, redirect_o=1, redirect_addr_o=0x80000040, stall_o[2:0]=0; all deassert next cycle.
- Deferred jump: stallreq_mem_i=1 for 3 cycles with jump_req_i pulsed on cycle 1 (addr 0x100) → no flush during the stall; flush_jump_o/redirect_o with addr 0x100 on the first cycle after the stall drops, exactly once.
- Interrupt drain: int_req_i pulsed (vector 0x200) while stallreq_exe_i=1 for 2 cycles → FSM DRAIN; one cycle after the stall clears, flush_int_o=int_ack_o=redirect_o=1 with addr 0x200; FSM back to IDLE.
- Collision: jump_req_i (0x300) and int_req_i (0x200) in the same unfrozen cycle → only flush_int_o, redirect_addr_o=0x200; no later jump flush. Also rst_i asserted during DRAIN → all outputs 0 immediately and no strobe afterward.
- Watchdog with WDOG_CYCLES=8: stallreq_mem_i held for 20 cycles → timeout_o pulses on cycles 8 and 16 only; a single-cycle drop of stallreq_mem_i restarts the count.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control constants: stall encodings, stage indices
// and interrupt FSM states.
package pipe_ctrl_pkg;

    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_EXE  = 6'b001111;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_NONE = 6'b000000;

    localparam int STG_PC      = 0;
    localparam int STG_IF_ID   = 1;
    localparam int STG_ID_EXE  = 2;
    localparam int STG_EXE_MEM = 3;
    localparam int STG_MEM_WB  = 4;
    localparam int STG_WB      = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } int_state_t;

    // Fixed priority MEM > EXE > ID > IF.
    function automatic logic [5:0] stall_sel(
        input logic mem,
        input logic exe,
        input logic id,
        input logic ifs
    );
        if (mem)
            return STALL_MEM;
        else if (exe)
            return STALL_EXE;
        else if (id)
            return STALL_ID;
        else if (ifs)
            return STALL_IF;
        return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_wdog.sv
// Bus-stall watchdog: pulses after WDOG_CYCLES consecutive MEM stalls,
// then restarts counting from zero.
module pipe_ctrl_wdog #(
    parameter int WDOG_CYCLES = 1024,
    parameter int WDOG_W      = 11
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic stall_i,
    output logic timeout_o
);

    localparam logic [WDOG_W-1:0] LAST = WDOG_W'(WDOG_CYCLES - 1);

    logic [WDOG_W-1:0] cnt;
    logic              hit;

    assign hit       = stall_i && (cnt == LAST);
    assign timeout_o = hit;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt <= '0;
        else if (!stall_i || hit)
            cnt <= '0;
        else
            cnt <= cnt + WDOG_W'(1);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: stall arbitration, jump/interrupt
// redirect sequencing and bus-stall watchdog.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int WDOG_CYCLES = 1024,
    parameter int WDOG_W      = 11
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stallreq_if_i,
    input  logic                  stallreq_id_i,
    input  logic                  stallreq_exe_i,
    input  logic                  stallreq_mem_i,
    input  logic                  jump_req_i,
    input  logic [ADDR_WIDTH-1:0] jump_addr_i,
    input  logic                  int_req_i,
    input  logic [ADDR_WIDTH-1:0] int_addr_i,
    output logic [5:0]            stall_o,
    output logic                  flush_jump_o,
    output logic                  flush_int_o,
    output logic                  redirect_o,
    output logic [ADDR_WIDTH-1:0] redirect_addr_o,
    output logic                  int_ack_o,
    output logic                  timeout_o
);

    int_state_t            state;
    logic                  pending;
    logic [ADDR_WIDTH-1:0] jump_addr_q;
    logic [ADDR_WIDTH-1:0] int_addr_q;

    logic                  frozen;
    logic                  idle;
    logic                  in_flush;
    logic                  jump_fire;
    logic [ADDR_WIDTH-1:0] jump_target;
    logic                  wdog_hit;

    assign frozen   = stallreq_mem_i | stallreq_exe_i;
    assign idle     = (state == IDLE);
    assign in_flush = (state == FLUSH);

    // An interrupt accepted this cycle discards any jump.
    assign jump_fire = idle && !int_req_i && !frozen
                    && (jump_req_i || pending);

    assign jump_target = jump_req_i ? jump_addr_i : jump_addr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            pending     <= 1'b0;
            jump_addr_q <= '0;
            int_addr_q  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (int_req_i) begin
                        int_addr_q <= int_addr_i;
                        state      <= frozen ? DRAIN : FLUSH;
                    end
                end
                DRAIN: begin
                    if (!frozen)
                        state <= FLUSH;
                end
                FLUSH:   state <= IDLE;
                default: state <= IDLE;
            endcase

            if (!idle || int_req_i || jump_fire) begin
                pending <= 1'b0;
            end else if (jump_req_i) begin
                pending     <= 1'b1;
                jump_addr_q <= jump_addr_i;
            end
        end
    end

    always_comb begin
        stall_o         = STALL_NONE;
        flush_jump_o    = 1'b0;
        flush_int_o     = 1'b0;
        redirect_o      = 1'b0;
        int_ack_o       = 1'b0;
        redirect_addr_o = '0;
        if (!rst_i) begin
            stall_o = stall_sel(stallreq_mem_i, stallreq_exe_i,
                                stallreq_id_i, stallreq_if_i);
            if (in_flush) begin
                stall_o         = STALL_NONE;
                flush_int_o     = 1'b1;
                redirect_o      = 1'b1;
                int_ack_o       = 1'b1;
                redirect_addr_o = int_addr_q;
            end else if (jump_fire) begin
                stall_o[STG_ID_EXE:STG_PC] = {3{NOSTOP}};
                flush_jump_o    = 1'b1;
                redirect_o      = 1'b1;
                redirect_addr_o = jump_target;
            end
        end
    end

    pipe_ctrl_wdog #(
        .WDOG_CYCLES(WDOG_CYCLES),
        .WDOG_W     (WDOG_W)
    ) u_wdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .stall_i  (stallreq_mem_i),
        .timeout_o(wdog_hit)
    );

    assign timeout_o = wdog_hit && !rst_i;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl with a shortened watchdog.
module tb_pipe_ctrl;

    localparam logic [4:0] S_NONE = 5'b00000;
    localparam logic [4:0] S_JMP  = 5'b10100;
    localparam logic [4:0] S_INT  = 5'b01110;

    logic        clk = 1'b0;
    logic        rst;
    logic        sif, sid, sexe, smem;
    logic        jreq, ireq;
    logic [31:0] jaddr, iaddr;
    logic [5:0]  stall;
    logic        fj, fi, rd, ack, to;
    logic [31:0] raddr;

    int n_cmp = 0;
    int n_err = 0;

    pipe_ctrl #(
        .ADDR_WIDTH (32),
        .WDOG_CYCLES(8),
        .WDOG_W     (4)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .stallreq_if_i  (sif),
        .stallreq_id_i  (sid),
        .stallreq_exe_i (sexe),
        .stallreq_mem_i (smem),
        .jump_req_i     (jreq),
        .jump_addr_i    (jaddr),
        .int_req_i      (ireq),
        .int_addr_i     (iaddr),
        .stall_o        (stall),
        .flush_jump_o   (fj),
        .flush_int_o    (fi),
        .redirect_o     (rd),
        .redirect_addr_o(raddr),
        .int_ack_o      (ack),
        .timeout_o      (to)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic m, input logic e,
                       input logic d, input logic f);
        smem = m;
        sexe = e;
        sid  = d;
        sif  = f;
    endtask

    task automatic ck(input string tag,
                      input logic [5:0] es,
                      input logic [4:0] eb,
                      input logic [31:0] ea);
        #1;
        check({tag, "/stall"}, 64'(stall), 64'(es));
        check({tag, "/strb"}, 64'({fj, fi, rd, ack, to}),
              64'(eb));
        check({tag, "/addr"}, 64'(raddr), 64'(ea));
    endtask

    initial begin
        rst   = 1'b1;
        req(1'b0, 1'b0, 1'b0, 1'b0);
        jreq  = 1'b0;
        ireq  = 1'b0;
        jaddr = '0;
        iaddr = '0;
        #2;
        ck("reset", 6'b0, S_NONE, 32'h0);
        cyc();
        rst = 1'b0;
        ck("idle", 6'b0, S_NONE, 32'h0);
        cyc();

        // arbitration
        req(1'b0, 1'b0, 1'b1, 1'b0);
        ck("arb_id", 6'b000111, S_NONE, 32'h0);
        req(1'b1, 1'b0, 1'b1, 1'b0);
        ck("arb_mem", 6'b011111, S_NONE, 32'h0);
        cyc();
        req(1'b0, 1'b1, 1'b0, 1'b1);
        ck("arb_exe", 6'b001111, S_NONE, 32'h0);
        req(1'b0, 1'b0, 1'b0, 1'b1);
        ck("arb_if", 6'b000011, S_NONE, 32'h0);
        cyc();
        req(1'b0, 1'b0, 1'b0, 1'b0);
        ck("arb_none", 6'b0, S_NONE, 32'h0);
        cyc();

        // unfrozen jump, flush clears low stall bits
        jreq  = 1'b1;
        jaddr = 32'h8000_0040;
        req(1'b0, 1'b0, 1'b0, 1'b1);
        ck("jmp_if", 6'b0, S_JMP, 32'h8000_0040);
        cyc();
        jaddr = 32'h8000_0044;
        req(1'b0, 1'b0, 1'b1, 1'b0);
        ck("jmp_id", 6'b0, S_JMP, 32'h8000_0044);
        cyc();
        jreq = 1'b0;
        req(1'b0, 1'b0, 1'b0, 1'b0);
        ck("jmp_done", 6'b0, S_NONE, 32'h0);
        cyc();

        // deferred jump behind a MEM stall
        req(1'b1, 1'b0, 1'b0, 1'b0);
        jreq  = 1'b1;
        jaddr = 32'h100;
        ck("defer1", 6'b011111, S_NONE, 32'h0);
        cyc();
        jreq  = 1'b0;
        jaddr = 32'hdead;
        ck("defer2", 6'b011111, S_NONE, 32'h0);
        cyc();
        ck("defer3", 6'b011111, S_NONE, 32'h0);
        cyc();
        req(1'b0, 1'b0, 1'b0, 1'b0);
        ck("defer_fire", 6'b0, S_JMP, 32'h100);
        cyc();
        ck("defer_once", 6'b0, S_NONE, 32'h0);
        cyc();

        // pending address overwritten by a newer jump
        req(1'b1, 1'b0, 1'b0, 1'b0);
        jreq  = 1'b1;
        jaddr = 32'h100;
        cyc();
        jaddr = 32'h104;
        cyc();
        jreq = 1'b0;
        req(1'b0, 1'b0, 1'b0, 1'b0);
        ck("ovr_fire", 6'b0, S_JMP, 32'h104);
        cyc();

        // interrupt drains behind an EXE stall
        req(1'b0, 1'b1, 1'b0, 1'b0);
        ireq  = 1'b1;
        iaddr = 32'h200;
        ck("drain1", 6'b001111, S_NONE, 32'h0);
        cyc();
        ireq  = 1'b0;
        iaddr = 32'h999;
        ck("drain2", 6'b001111, S_NONE, 32'h0);
        cyc();
        req(1'b0, 1'b0, 1'b0, 1'b0);
        ck("drain3", 6'b0, S_NONE, 32'h0);
        cyc();
        req(1'b0, 1'b0, 1'b1, 1'b0);
        ck("int_fire", 6'b0, S_INT, 32'h200);
        cyc();
        req(1'b0, 1'b0, 1'b0, 1'b0);
        ck("int_idle", 6'b0, S_NONE, 32'h0);
        cyc();

        // jump/interrupt collision
        jreq  = 1'b1;
        jaddr = 32'h300;
        ireq  = 1'b1;
        iaddr = 32'h200;
        ck("coll1", 6'b0, S_NONE, 32'h0);
        cyc();
        jreq = 1'b0;
        ireq = 1'b0;
        ck("coll_int", 6'b0, S_INT, 32'h200);
        cyc();
        ck("coll_after", 6'b0, S_NONE, 32'h0);
        cyc();

        // pending jump dropped by interrupt; FLUSH ignores int_req
        req(1'b1, 1'b0, 1'b0, 1'b0);
        jreq  = 1'b1;
        jaddr = 32'h400;
        cyc();
        jreq  = 1'b0;
        ireq  = 1'b1;
        iaddr = 32'h500;
        cyc();
        ireq = 1'b0;
        req(1'b0, 1'b0, 1'b0, 1'b0);
        ck("pj_drain", 6'b0, S_NONE, 32'h0);
        cyc();
        ireq  = 1'b1;
        iaddr = 32'h600;
        ck("pj_int", 6'b0, S_INT, 32'h500);
        cyc();
        ireq = 1'b0;
        ck("pj_quiet", 6'b0, S_NONE, 32'h0);
        cyc();

        // reset during DRAIN
        req(1'b0, 1'b1, 1'b0, 1'b0);
        ireq  = 1'b1;
        iaddr = 32'h700;
        cyc();
        ireq = 1'b0;
        rst  = 1'b1;
        ck("rst_drain", 6'b0, S_NONE, 32'h0);
        cyc();
        rst = 1'b0;
        req(1'b0, 1'b0, 1'b0, 1'b0);
        ck("rst_rel", 6'b0, S_NONE, 32'h0);
        cyc();
        ck("rst_quiet", 6'b0, S_NONE, 32'h0);
        cyc();

        // reset with a pending jump
        req(1'b1, 1'b0, 1'b0, 1'b0);
        jreq  = 1'b1;
        jaddr = 32'h800;
        cyc();
        jreq = 1'b0;
        rst  = 1'b1;
        cyc();
        rst = 1'b0;
        req(1'b0, 1'b0, 1'b0, 1'b0);
        ck("rst_pend", 6'b0, S_NONE, 32'h0);
        cyc();

        // watchdog: 20 consecutive MEM stalls
        smem = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            #1;
            check($sformatf("wdog%0d", i), 64'(to),
                  64'((i == 8) || (i == 16)));
            if (i == 8)
                check("wdog_stall", 64'(stall), 64'h1f);
            cyc();
        end
        smem = 1'b0;
        cyc();

        // single-cycle drop restarts the count
        for (int i = 1; i <= 14; i++) begin
            smem = (i != 6);
            #1;
            check($sformatf("wdrop%0d", i), 64'(to),
                  64'(i == 14));
            cyc();
        end
        smem = 1'b0;
        ck("end", 6'b0, S_NONE, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
